// File: rtl/mdu_sequencer.sv
// HI/LO multiply/divide sequencer: captures the result at acceptance, holds busy
// for a fixed latency, then commits to HI/LO; also serves MT/MF HI/LO and D-stage stall.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mduop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [1:0]  read_hilo,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CW = 4;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   hi_s, lo_s;
    logic          wr_s;

    logic [31:0]   hi_n, lo_n;
    logic          wr_n;
    logic [63:0]   prod;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag;
    logic          a_neg, b_neg;
    logic          accept;

    assign accept = start && (mduop >= OP_MULT) && (mduop <= OP_DIVU);

    // Shadow result: signed divide done on magnitudes, then signs restored
    // (quotient truncates toward zero, remainder follows the dividend).
    always_comb begin
        hi_n  = '0;
        lo_n  = '0;
        wr_n  = 1'b1;
        prod  = '0;
        a_neg = (mduop == OP_DIV) && rs_val[31];
        b_neg = (mduop == OP_DIV) && rt_val[31];
        a_mag = a_neg ? (~rs_val + 32'd1) : rs_val;
        b_mag = b_neg ? (~rt_val + 32'd1) : rt_val;
        q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        case (mduop)
            OP_MULT: begin
                prod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
                hi_n = prod[63:32];
                lo_n = prod[31:0];
            end
            OP_MULTU: begin
                prod = {32'd0, rs_val} * {32'd0, rt_val};
                hi_n = prod[63:32];
                lo_n = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                wr_n = (rt_val != 32'd0);
                lo_n = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
                hi_n = a_neg ? (~r_mag + 32'd1) : r_mag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            hi_s  <= '0;
            lo_s  <= '0;
            wr_s  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        count <= (mduop <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        hi_s  <= hi_n;
                        lo_s  <= lo_n;
                        wr_s  <= wr_n;
                    end else if (mduop == OP_MTHI) begin
                        hi <= rs_val;
                    end else if (mduop == OP_MTLO) begin
                        lo <= rs_val;
                    end
                end
                RUN: begin
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                        if (wr_s) begin
                            hi <= hi_s;
                            lo <= lo_s;
                        end
                    end else begin
                        count <= count - CW'(1);
                    end
                end
            endcase
        end
    end

    assign stall = md_in_d & (start | busy);

    always_comb begin
        case (read_hilo)
            2'b10:   rdata = hi;
            2'b01:   rdata = lo;
            default: rdata = '0;
        endcase
    end

endmodule
